// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive control path: FSM state encoding,
// default frame width and the oversampling ratios the bit timing supports.
package uart_rx_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int PRESCALE_W_DEF = 6;

   localparam int PRESCALE_8  = 8;
   localparam int PRESCALE_16 = 16;
   localparam int PRESCALE_32 = 32;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   function automatic logic prescale_legal(input int p);
      return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
   endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Control/status bundle between the UART RX FSM (master) and its datapath
// (sampler, deserializer, checkers). UART_RX_FRAME_ERR_CNT_EN adds frame_err_cnt.
interface uart_rx_fsm_if
   import uart_rx_pkg::*;
#(
   parameter int PRESCALE_W = PRESCALE_W_DEF
);
   logic                  rx_in;
   logic [PRESCALE_W-1:0] prescale;
   logic                  par_en;
   logic                  start_glitch;
   logic                  par_err;
   logic                  stop_err;
   logic [PRESCALE_W-1:0] edge_cnt;
   logic [3:0]            bit_cnt;
   logic                  sample_en;
   logic                  deser_en;
   logic                  start_chk_en;
   logic                  par_chk_en;
   logic                  stop_chk_en;
   logic                  err_clr;
   logic                  data_valid;
   logic                  busy;
`ifdef UART_RX_FRAME_ERR_CNT_EN
   logic [7:0]            frame_err_cnt;
`endif

   modport master (
      input  rx_in, prescale, par_en, start_glitch, par_err, stop_err,
      output edge_cnt, bit_cnt, sample_en, deser_en, start_chk_en,
             par_chk_en, stop_chk_en, err_clr, data_valid, busy
`ifdef UART_RX_FRAME_ERR_CNT_EN
      , output frame_err_cnt
`endif
   );

   modport slave (
      output rx_in, prescale, par_en, start_glitch, par_err, stop_err,
      input  edge_cnt, bit_cnt, sample_en, deser_en, start_chk_en,
             par_chk_en, stop_chk_en, err_clr, data_valid, busy
`ifdef UART_RX_FRAME_ERR_CNT_EN
      , input frame_err_cnt
`endif
   );

endinterface

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample edge counter and frame bit counter for the UART RX FSM.
// bit_end marks the last oversample edge of the current bit.
module uart_rx_edge_bit_cnt
   import uart_rx_pkg::*;
#(
   parameter int PRESCALE_W = PRESCALE_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  cnt_en,
   input  logic                  bit_inc,
   input  logic                  cnt_clr,
   output logic [PRESCALE_W-1:0] edge_cnt,
   output logic [3:0]            bit_cnt,
   output logic                  bit_end
);

   assign bit_end = cnt_en && (edge_cnt == prescale - PRESCALE_W'(1));

   // NOTE: non-blocking assignments so both counters update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_cnt <= '0;
         bit_cnt  <= '0;
      end else if (cnt_clr) begin
         edge_cnt <= '0;
         bit_cnt  <= '0;
      end else if (cnt_en) begin
         edge_cnt <= bit_end ? '0 : edge_cnt + PRESCALE_W'(1);
         if (bit_inc) begin
            bit_cnt <= bit_cnt + 4'd1;
         end
      end
   end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive control FSM: start detection, bit timing, checker strobes and
// data_valid. Optional frame error counter under UART_RX_FRAME_ERR_CNT_EN.
module uart_rx_fsm
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int PRESCALE_W = PRESCALE_W_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   uart_rx_fsm_if.master  bus
);

   state_t state, state_nxt;
   logic   par_en_q;
   logic   drop;
   logic   start_frame;
   logic   strobe;
   logic   bit_end;
   logic   bit_inc;
   logic   cnt_en;
   logic   cnt_clr;
   logic   deser_en, start_chk_en, par_chk_en, stop_chk_en, data_valid;

   assign cnt_en      = (state != IDLE);
   assign cnt_clr     = (state == IDLE);
   assign start_frame = (state == IDLE) && !bus.rx_in;
   // Checkers sample at edge prescale-2 so their registered flag is ready at bit end.
   assign strobe      = (bus.edge_cnt == bus.prescale - PRESCALE_W'(2));

   uart_rx_edge_bit_cnt #(
      .PRESCALE_W (PRESCALE_W)
   ) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .prescale (bus.prescale),
      .cnt_en   (cnt_en),
      .bit_inc  (bit_inc),
      .cnt_clr  (cnt_clr),
      .edge_cnt (bus.edge_cnt),
      .bit_cnt  (bus.bit_cnt),
      .bit_end  (bit_end)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         par_en_q <= 1'b0;
         drop     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (start_frame) begin
            par_en_q <= bus.par_en;
            drop     <= 1'b0;
         end else if ((state == PARITY) && bit_end && bus.par_err) begin
            drop <= 1'b1;
         end
      end
   end

   // NOTE: every output gets a default first, so no branch can infer a latch.
   always_comb begin
      state_nxt    = state;
      bit_inc      = 1'b0;
      deser_en     = 1'b0;
      start_chk_en = 1'b0;
      par_chk_en   = 1'b0;
      stop_chk_en  = 1'b0;
      data_valid   = 1'b0;
      case (state)
         IDLE: begin
            if (!bus.rx_in) state_nxt = START;
         end
         START: begin
            start_chk_en = strobe;
            if (bit_end) begin
               if (bus.start_glitch) begin
                  state_nxt = IDLE;
               end else begin
                  state_nxt = DATA;
                  bit_inc   = 1'b1;
               end
            end
         end
         DATA: begin
            deser_en = strobe;
            if (bit_end) begin
               if (bus.bit_cnt == 4'(DATA_WIDTH)) begin
                  state_nxt = par_en_q ? PARITY : STOP;
               end else begin
                  bit_inc = 1'b1;
               end
            end
         end
         PARITY: begin
            par_chk_en = strobe;
            if (bit_end) state_nxt = STOP;
         end
         STOP: begin
            stop_chk_en = strobe;
            if (bit_end) begin
               state_nxt  = IDLE;
               data_valid = !bus.stop_err && !drop;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.sample_en    = cnt_en;
   assign bus.busy         = cnt_en;
   assign bus.err_clr      = start_frame;
   assign bus.deser_en     = deser_en;
   assign bus.start_chk_en = start_chk_en;
   assign bus.par_chk_en   = par_chk_en;
   assign bus.stop_chk_en  = stop_chk_en;
   assign bus.data_valid   = data_valid;

`ifdef UART_RX_FRAME_ERR_CNT_EN
   logic       frame_drop;
   logic [7:0] frame_err_cnt;

   assign frame_drop = bit_end &&
                       (((state == START) && bus.start_glitch) ||
                        ((state == STOP) && (bus.stop_err || drop)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_err_cnt <= 8'd0;
      end else if (frame_drop && (frame_err_cnt != 8'hFF)) begin
         frame_err_cnt <= frame_err_cnt + 8'd1;
      end
   end

   assign bus.frame_err_cnt = frame_err_cnt;
`else
   // Without the counter, dropped frames are only visible as a missing data_valid.
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: drives serial frames and registered checker
// flags cycle by cycle, counts the FSM strobes and checks them against hand values.
module tb_uart_rx_fsm;

   localparam int PW = 6;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   vecs = 0;
   int   errs = 0;

   int   n_deser, n_start_chk, n_par_chk, n_stop_chk, n_err_clr, n_dv, n_sample;
   int   dv_cyc, first_dv_cyc, last_busy_cyc, par_chk_edge, stop_chk_edge;

   uart_rx_fsm_if #(.PRESCALE_W(PW)) bus ();

   uart_rx_fsm #(.DATA_WIDTH(8), .PRESCALE_W(PW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.deser_en)     n_deser++;
         if (bus.start_chk_en) n_start_chk++;
         if (bus.par_chk_en)  begin n_par_chk++;  par_chk_edge  = int'(bus.edge_cnt); end
         if (bus.stop_chk_en) begin n_stop_chk++; stop_chk_edge = int'(bus.edge_cnt); end
         if (bus.err_clr)      n_err_clr++;
         if (bus.data_valid) begin
            if (n_dv == 0) first_dv_cyc = cyc;
            n_dv++;
            dv_cyc = cyc;
         end
         if (bus.sample_en)    n_sample++;
         if (bus.busy)         last_busy_cyc = cyc;
      end
   end

   task automatic clear_mon();
      n_deser = 0; n_start_chk = 0; n_par_chk = 0; n_stop_chk = 0;
      n_err_clr = 0; n_dv = 0; n_sample = 0;
      dv_cyc = -1; first_dv_cyc = -1; last_busy_cyc = -1;
      par_chk_edge = -1; stop_chk_edge = -1;
   endtask

   // Drives one frame starting in the current cycle (k = 0 is the IDLE->START
   // transition cycle). Checker flags change on the cycle after their strobe,
   // as a registered checker would. glitch_len > 0 drives only a short low pulse.
   task automatic run_frame(input int p, input logic [7:0] data, input bit pe,
                            input bit par_flip, input bit stop_bit, input bit sg,
                            input bit pe_err, input bit se, input int glitch_len,
                            input int last_k, input int pe_flip_k, output int t0);
      logic [11:0] bits;
      int nbits;
      bits    = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[1+i] = data[i];
      if (pe) begin
         bits[9]  = (^data) ^ par_flip;
         bits[10] = stop_bit;
      end else begin
         bits[9]  = stop_bit;
      end
      nbits = pe ? 11 : 10;
      if (last_k < 0) last_k = (glitch_len > 0) ? p : nbits * p;
      bus.prescale = PW'(p);
      bus.par_en   = pe;
      t0 = cyc;
      for (int k = 0; k <= last_k; k++) begin
         if (glitch_len > 0) bus.rx_in = (k < glitch_len) ? 1'b0 : 1'b1;
         else                bus.rx_in = (k < nbits * p) ? bits[k / p] : 1'b1;
         if (k == 1) begin
            bus.start_glitch = 1'b0; bus.par_err = 1'b0; bus.stop_err = 1'b0;
         end
         if (k == p)              bus.start_glitch = sg;
         if (pe && k == 10 * p)   bus.par_err = pe_err;
         if (k == nbits * p)      bus.stop_err = se;
         if (k == pe_flip_k)      bus.par_en = !pe;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vecs++; if (bus.busy !== 1'b0)       begin errs++; $display("FAIL reset.busy got %b want 0", bus.busy); end
      vecs++; if (bus.sample_en !== 1'b0)  begin errs++; $display("FAIL reset.sample_en got %b want 0", bus.sample_en); end
      vecs++; if (bus.data_valid !== 1'b0) begin errs++; $display("FAIL reset.data_valid got %b want 0", bus.data_valid); end
      vecs++; if (bus.err_clr !== 1'b0)    begin errs++; $display("FAIL reset.err_clr got %b want 0", bus.err_clr); end
      vecs++; if (bus.edge_cnt !== '0)     begin errs++; $display("FAIL reset.edge_cnt got %0d want 0", bus.edge_cnt); end
      vecs++; if (bus.bit_cnt !== 4'd0)    begin errs++; $display("FAIL reset.bit_cnt got %0d want 0", bus.bit_cnt); end
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      vecs++; if (bus.busy !== 1'b0)       begin errs++; $display("FAIL reset.idle_busy got %b want 0", bus.busy); end
`ifdef UART_RX_FRAME_ERR_CNT_EN
      vecs++; if (bus.frame_err_cnt !== 8'd0) begin errs++; $display("FAIL reset.frame_err_cnt got %0d want 0", bus.frame_err_cnt); end
`endif
   endtask

   task automatic test_basic_p8();
      int t0;
      clear_mon();
      run_frame(8, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, -1, -1, t0);
      vecs++; if (n_dv != 1)           begin errs++; $display("FAIL basic.dv_count got %0d want 1", n_dv); end
      vecs++; if (dv_cyc - t0 != 80)   begin errs++; $display("FAIL basic.dv_latency got %0d want 80", dv_cyc - t0); end
      vecs++; if (n_deser != 8)        begin errs++; $display("FAIL basic.deser_count got %0d want 8", n_deser); end
      vecs++; if (n_stop_chk != 1)     begin errs++; $display("FAIL basic.stop_chk_count got %0d want 1", n_stop_chk); end
      vecs++; if (n_start_chk != 1)    begin errs++; $display("FAIL basic.start_chk_count got %0d want 1", n_start_chk); end
      vecs++; if (n_par_chk != 0)      begin errs++; $display("FAIL basic.par_chk_count got %0d want 0", n_par_chk); end
      vecs++; if (n_err_clr != 1)      begin errs++; $display("FAIL basic.err_clr_count got %0d want 1", n_err_clr); end
      vecs++; if (n_sample != 80)      begin errs++; $display("FAIL basic.sample_cycles got %0d want 80", n_sample); end
      vecs++; if (bus.busy !== 1'b0)   begin errs++; $display("FAIL basic.busy_after got %b want 0", bus.busy); end
   endtask

   task automatic test_parity_p16();
      int t0;
      clear_mon();
      run_frame(16, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, -1, -1, t0);
      vecs++; if (n_dv != 1)           begin errs++; $display("FAIL parity.dv_count got %0d want 1", n_dv); end
      vecs++; if (dv_cyc - t0 != 176)  begin errs++; $display("FAIL parity.dv_latency got %0d want 176", dv_cyc - t0); end
      vecs++; if (n_par_chk != 1)      begin errs++; $display("FAIL parity.par_chk_count got %0d want 1", n_par_chk); end
      vecs++; if (par_chk_edge != 14)  begin errs++; $display("FAIL parity.par_chk_edge got %0d want 14", par_chk_edge); end
      vecs++; if (n_stop_chk != 1)     begin errs++; $display("FAIL parity.stop_chk_count got %0d want 1", n_stop_chk); end
      vecs++; if (stop_chk_edge != 14) begin errs++; $display("FAIL parity.stop_chk_edge got %0d want 14", stop_chk_edge); end
      vecs++; if (n_deser != 8)        begin errs++; $display("FAIL parity.deser_count got %0d want 8", n_deser); end
   endtask

   task automatic test_glitch();
      int t0;
      clear_mon();
      run_frame(8, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3, -1, -1, t0);
      repeat (4) @(posedge clk);
      #1;
      vecs++; if (n_dv != 0)           begin errs++; $display("FAIL glitch.dv_count got %0d want 0", n_dv); end
      vecs++; if (n_deser != 0)        begin errs++; $display("FAIL glitch.deser_count got %0d want 0", n_deser); end
      vecs++; if (n_start_chk != 1)    begin errs++; $display("FAIL glitch.start_chk_count got %0d want 1", n_start_chk); end
      vecs++; if (n_sample != 8)       begin errs++; $display("FAIL glitch.sample_cycles got %0d want 8", n_sample); end
      vecs++; if (bus.busy !== 1'b0)   begin errs++; $display("FAIL glitch.busy_after got %b want 0", bus.busy); end
      vecs++; if (bus.bit_cnt !== 4'd0) begin errs++; $display("FAIL glitch.bit_cnt got %0d want 0", bus.bit_cnt); end
`ifdef UART_RX_FRAME_ERR_CNT_EN
      vecs++; if (bus.frame_err_cnt !== 8'd1) begin errs++; $display("FAIL glitch.frame_err_cnt got %0d want 1", bus.frame_err_cnt); end
`endif
   endtask

   task automatic test_stop_err();
      int t0;
      clear_mon();
      run_frame(8, 8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, -1, -1, t0);
      vecs++; if (n_dv != 0)           begin errs++; $display("FAIL stop_err.dv_count got %0d want 0", n_dv); end
      vecs++; if (n_stop_chk != 1)     begin errs++; $display("FAIL stop_err.stop_chk_count got %0d want 1", n_stop_chk); end
      vecs++; if (bus.busy !== 1'b0)   begin errs++; $display("FAIL stop_err.busy_after got %b want 0", bus.busy); end
`ifdef UART_RX_FRAME_ERR_CNT_EN
      vecs++; if (bus.frame_err_cnt !== 8'd2) begin errs++; $display("FAIL stop_err.frame_err_cnt got %0d want 2", bus.frame_err_cnt); end
`endif
      repeat (2) @(posedge clk);
      #1;
      clear_mon();
      run_frame(8, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, -1, -1, t0);
      vecs++; if (n_err_clr != 1)      begin errs++; $display("FAIL stop_err.next_err_clr got %0d want 1", n_err_clr); end
      vecs++; if (n_dv != 1)           begin errs++; $display("FAIL stop_err.next_dv_count got %0d want 1", n_dv); end
      vecs++; if (dv_cyc - t0 != 80)   begin errs++; $display("FAIL stop_err.next_dv_latency got %0d want 80", dv_cyc - t0); end
   endtask

   task automatic test_par_err_p32();
      int t0;
      clear_mon();
      run_frame(32, 8'h5B, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, -1, -1, t0);
      vecs++; if (n_dv != 0)                  begin errs++; $display("FAIL par_err.dv_count got %0d want 0", n_dv); end
      vecs++; if (last_busy_cyc - t0 != 352)  begin errs++; $display("FAIL par_err.stop_end got %0d want 352", last_busy_cyc - t0); end
      vecs++; if (n_par_chk != 1)             begin errs++; $display("FAIL par_err.par_chk_count got %0d want 1", n_par_chk); end
      vecs++; if (n_stop_chk != 1)            begin errs++; $display("FAIL par_err.stop_chk_count got %0d want 1", n_stop_chk); end
      vecs++; if (par_chk_edge != 30)         begin errs++; $display("FAIL par_err.par_chk_edge got %0d want 30", par_chk_edge); end
`ifdef UART_RX_FRAME_ERR_CNT_EN
      vecs++; if (bus.frame_err_cnt !== 8'd3) begin errs++; $display("FAIL par_err.frame_err_cnt got %0d want 3", bus.frame_err_cnt); end
`endif
   endtask

   task automatic test_back_to_back();
      int t0a, t0b;
      clear_mon();
      run_frame(8, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, -1, 20, t0a);
      run_frame(8, 8'hEE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, -1, -1, t0b);
      vecs++; if (n_dv != 2)                  begin errs++; $display("FAIL b2b.dv_count got %0d want 2", n_dv); end
      vecs++; if (first_dv_cyc - t0a != 80)   begin errs++; $display("FAIL b2b.first_latency got %0d want 80", first_dv_cyc - t0a); end
      vecs++; if (dv_cyc - t0b != 80)         begin errs++; $display("FAIL b2b.second_latency got %0d want 80", dv_cyc - t0b); end
      vecs++; if (n_err_clr != 2)             begin errs++; $display("FAIL b2b.err_clr_count got %0d want 2", n_err_clr); end
      vecs++; if (n_sample != 160)            begin errs++; $display("FAIL b2b.sample_cycles got %0d want 160", n_sample); end
      vecs++; if (n_par_chk != 0)             begin errs++; $display("FAIL b2b.par_chk_count got %0d want 0", n_par_chk); end
   endtask

   task automatic test_reset_mid_frame();
      int t0;
      clear_mon();
      run_frame(8, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 34, -1, t0);
      vecs++; if (bus.bit_cnt !== 4'd4)   begin errs++; $display("FAIL midrst.pre_bit_cnt got %0d want 4", bus.bit_cnt); end
      vecs++; if (bus.edge_cnt !== PW'(2)) begin errs++; $display("FAIL midrst.pre_edge_cnt got %0d want 2", bus.edge_cnt); end
      vecs++; if (bus.busy !== 1'b1)      begin errs++; $display("FAIL midrst.pre_busy got %b want 1", bus.busy); end
      rst_n = 1'b0;
      bus.rx_in = 1'b1;
      #1;
      vecs++; if (bus.busy !== 1'b0)       begin errs++; $display("FAIL midrst.busy got %b want 0", bus.busy); end
      vecs++; if (bus.sample_en !== 1'b0)  begin errs++; $display("FAIL midrst.sample_en got %b want 0", bus.sample_en); end
      vecs++; if (bus.bit_cnt !== 4'd0)    begin errs++; $display("FAIL midrst.bit_cnt got %0d want 0", bus.bit_cnt); end
      vecs++; if (bus.edge_cnt !== '0)     begin errs++; $display("FAIL midrst.edge_cnt got %0d want 0", bus.edge_cnt); end
      vecs++; if (bus.deser_en !== 1'b0)   begin errs++; $display("FAIL midrst.deser_en got %b want 0", bus.deser_en); end
      vecs++; if (bus.data_valid !== 1'b0) begin errs++; $display("FAIL midrst.data_valid got %b want 0", bus.data_valid); end
`ifdef UART_RX_FRAME_ERR_CNT_EN
      vecs++; if (bus.frame_err_cnt !== 8'd0) begin errs++; $display("FAIL midrst.frame_err_cnt got %0d want 0", bus.frame_err_cnt); end
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      clear_mon();
      run_frame(8, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, -1, -1, t0);
      vecs++; if (n_dv != 1)           begin errs++; $display("FAIL midrst.next_dv_count got %0d want 1", n_dv); end
      vecs++; if (dv_cyc - t0 != 80)   begin errs++; $display("FAIL midrst.next_dv_latency got %0d want 80", dv_cyc - t0); end
   endtask

   initial begin
      rst_n            = 1'b0;
      bus.rx_in        = 1'b1;
      bus.prescale     = PW'(8);
      bus.par_en       = 1'b0;
      bus.start_glitch = 1'b0;
      bus.par_err      = 1'b0;
      bus.stop_err     = 1'b0;
      clear_mon();
      test_reset();
      test_basic_p8();
      test_parity_p16();
      test_glitch();
      test_stop_err();
      test_par_err_p32();
      test_back_to_back();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
